// File: rtl/hog_pix_feeder_if.sv
// Bundle between the pixel feeder, its pixel RAM and the HOG core.
// The master side is the feeder; the slave side is RAM/core/control.
interface hog_pix_feeder_if #(
  parameter int PIX_W  = 8,
  parameter int ADDR_W = 13
);
  logic              start;
  logic              busy;
  logic              done;
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [PIX_W-1:0]  mem_rdata;
  logic              request;
  logic              ready;
  logic [4*PIX_W-1:0] o_data;

  modport master (
    input  start, mem_rdata, request,
    output busy, done, mem_rd, mem_addr, ready, o_data
  );

  modport slave (
    output start, mem_rdata, request,
    input  busy, done, mem_rd, mem_addr, ready, o_data
  );
endinterface

// File: rtl/hog_pix_feeder.sv
// Raster-scans a frame and feeds {top,bot,left,right} neighbour words,
// with border replication, to a HOG core over a ready/request handshake.
module hog_pix_feeder #(
  parameter int PIX_W  = 8,
  parameter int IMG_W  = 64,
  parameter int IMG_H  = 128,
  parameter int ADDR_W = 13
) (
  input  logic clk,
  input  logic rst,
  hog_pix_feeder_if.master bus
);
  localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int DW = 4 * PIX_W;
  localparam logic [XW-1:0] XMAX = XW'(IMG_W - 1);
  localparam logic [YW-1:0] YMAX = YW'(IMG_H - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_PRESENT,
    S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [DW-1:0] data_q, data_d;

  logic [YW-1:0] yt, yb, row;
  logic [XW-1:0] xl, xr, col;
  logic [1:0]    fld;

  assign yt = (y_q == '0)   ? y_q : y_q - 1'b1;
  assign yb = (y_q == YMAX) ? y_q : y_q + 1'b1;
  assign xl = (x_q == '0)   ? x_q : x_q - 1'b1;
  assign xr = (x_q == XMAX) ? x_q : x_q + 1'b1;

  // Read slot k (cnt 0..3) fetches neighbour k; capture lands one cycle later.
  always_comb begin
    row = y_q;
    col = x_q;
    unique case (cnt_q[1:0])
      2'd0: row = yt;
      2'd1: row = yb;
      2'd2: col = xl;
      2'd3: col = xr;
    endcase
  end

  assign bus.mem_addr = ADDR_W'(row) * ADDR_W'(IMG_W) + ADDR_W'(col);
  assign fld = 2'd0 - cnt_q[1:0];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    cnt_d      = cnt_q;
    data_d     = data_q;
    bus.busy   = 1'b0;
    bus.done   = 1'b0;
    bus.mem_rd = 1'b0;
    bus.ready  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          x_d     = '0;
          y_d     = '0;
          cnt_d   = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        bus.busy   = 1'b1;
        bus.mem_rd = ~cnt_q[2];
        cnt_d      = cnt_q + 3'd1;
        if (cnt_q != 3'd0)
          data_d[fld*PIX_W +: PIX_W] = bus.mem_rdata;
        if (cnt_q == 3'd4)
          state_d = S_PRESENT;
      end
      S_PRESENT: begin
        bus.busy  = 1'b1;
        bus.ready = 1'b1;
        if (bus.request) begin
          cnt_d   = '0;
          state_d = S_FETCH;
          if (x_q == XMAX) begin
            x_d = '0;
            y_d = y_q + 1'b1;
            if (y_q == YMAX)
              state_d = S_DONE;
          end else begin
            x_d = x_q + 1'b1;
          end
        end
      end
      S_DONE: begin
        bus.done = 1'b1;
        state_d  = S_IDLE;
      end
    endcase
  end

  assign bus.o_data = data_q;
endmodule

// File: tb/tb_hog_pix_feeder.sv
// Directed + randomized checks of hog_pix_feeder on a 4x3 frame
// whose RAM returns its own address as data.
module tb_hog_pix_feeder;
  localparam int PW = 8;
  localparam int W  = 4;
  localparam int H  = 3;
  localparam int AW = 13;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  hog_pix_feeder_if #(.PIX_W(PW), .ADDR_W(AW)) bus ();

  hog_pix_feeder #(
    .PIX_W(PW), .IMG_W(W), .IMG_H(H), .ADDR_W(AW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  int done_cnt = 0;
  logic [31:0] words[$];

  always @(posedge clk) begin
    if (bus.mem_rd) bus.mem_rdata <= PW'(bus.mem_addr);
    if (rst && bus.ready && bus.request) words.push_back(bus.o_data);
    if (bus.done) done_cnt++;
  end

  function automatic logic [31:0] exp_word(int x, int y);
    int t, b, l, r;
    t = (y == 0) ? y : y - 1;
    b = (y == H - 1) ? y : y + 1;
    l = (x == 0) ? x : x - 1;
    r = (x == W - 1) ? x : x + 1;
    return {8'(t * W + x), 8'(b * W + x), 8'(y * W + l), 8'(y * W + r)};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_frame(input string tag);
    int bad = 0;
    chk({tag, "_count"}, 64'(words.size()), 64'(W * H));
    for (int i = 0; i < words.size() && i < W * H; i++)
      if (words[i] !== exp_word(i % W, i / W)) bad++;
    chk({tag, "_words"}, 64'(bad), 64'd0);
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_ready(input string tag);
    int i = 0;
    while (!bus.ready && i < 50) begin
      @(negedge clk);
      i++;
    end
    chk({tag, "_ready_timeout"}, 64'(bus.ready), 64'd1);
  endtask

  task automatic wait_done(input string tag, input bit rnd);
    int i = 0;
    while (done_cnt == 0 && i < 2000) begin
      if (rnd) bus.request = 1'($urandom_range(0, 1));
      @(negedge clk);
      i++;
    end
    chk({tag, "_done_timeout"}, 64'(done_cnt != 0), 64'd1);
  endtask

  initial begin
    logic [4:0]  rdpat;
    logic [31:0] hold;
    int gap, bad;
    bit seen;

    bus.start   = 1'b1;
    bus.request = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_outs", {bus.busy, bus.done, bus.ready, bus.mem_rd, bus.o_data},
        64'd0);
    rst = 1'b1;
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    chk("start_in_reset_ignored", {bus.busy, bus.mem_rd}, 64'd0);

    // Frame 1: request held high, latency and busy checks.
    words.delete();
    done_cnt = 0;
    bus.request = 1'b1;
    pulse_start();
    chk("busy_after_start", 64'(bus.busy), 64'd1);
    rdpat = '0;
    seen = 0;
    for (int c = 0; c < 5; c++) begin
      rdpat[c] = bus.mem_rd;
      if (bus.ready) seen = 1;
      @(negedge clk);
    end
    chk("mem_rd_pattern", 64'(rdpat), 64'b01111);
    chk("ready_not_early", 64'(seen), 64'd0);
    chk("ready_at_5", 64'(bus.ready), 64'd1);
    chk("first_word", 64'(bus.o_data), 64'h00040001);
    gap = 0;
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      if (bus.done) seen = 1;
      else begin
        if (!bus.busy) gap++;
        @(negedge clk);
      end
    end
    chk("f1_done_seen", 64'(seen), 64'd1);
    chk("f1_busy_gap", 64'(gap), 64'd0);
    chk("done_cycle_outs", {bus.busy, bus.ready}, 64'd0);
    @(negedge clk);
    chk("done_one_cycle", {bus.done, bus.busy}, 64'd0);
    chk("f1_done_cnt", 64'(done_cnt), 64'd1);
    chk_frame("f1");
    if (words.size() == W * H) begin
      chk("pix_1_1", 64'(words[5]), 64'h01090406);
      chk("pix_3_2", 64'(words[11]), 64'h070B0A0B);
    end

    // Frame 2: backpressure, stray start, random request.
    repeat ($urandom_range(1, 4)) @(negedge clk);
    words.delete();
    done_cnt = 0;
    bus.request = 1'b0;
    pulse_start();
    wait_ready("f2");
    hold = bus.o_data;
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (!bus.ready || bus.mem_rd || bus.o_data !== hold) bad++;
    end
    chk("bp_hold", 64'(bad), 64'd0);
    chk("bp_no_xfer", 64'(words.size()), 64'd0);
    bus.request = 1'b1;
    @(negedge clk);
    bus.request = 1'b0;
    @(negedge clk);
    chk("bp_one_xfer", 64'(words.size()), 64'd1);
    chk("bp_ready_low", 64'(bus.ready), 64'd0);
    pulse_start();
    wait_done("f2", 1'b1);
    bus.request = 1'b0;
    repeat (3) @(negedge clk);
    chk("f2_done_cnt", 64'(done_cnt), 64'd1);
    chk("f2_idle", 64'(bus.busy), 64'd0);
    chk_frame("f2");

    // Frame 3: reset during the fifth pixel's fetch.
    words.delete();
    done_cnt = 0;
    bus.request = 1'b1;
    pulse_start();
    for (int i = 0; i < 100 && words.size() < 4; i++) @(negedge clk);
    chk("f3_four_xfers", 64'(words.size()), 64'd4);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_outs", {bus.busy, bus.done, bus.ready, bus.mem_rd, bus.o_data},
        64'd0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrst_no_done", 64'(done_cnt), 64'd0);
    chk("midrst_idle", 64'(bus.busy), 64'd0);
    words.delete();
    pulse_start();
    wait_ready("f4");
    chk("restart_word", 64'(bus.o_data), 64'h00040001);
    wait_done("f4", 1'b1);
    bus.request = 1'b0;
    repeat (2) @(negedge clk);
    chk_frame("f4");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/hog_pix_feeder.md
HOG_PIX_FEEDER -- requirements
Module: hog_pix_feeder

Interface
REQ-001 SHALL have parameter PIX_W, default 8, pixel width in bits.
REQ-002 SHALL have parameter IMG_W, default 64, image width in pixels.
REQ-003 SHALL have parameter IMG_H, default 128, image height in pixels.
REQ-004 SHALL have parameter ADDR_W, default 13, pixel RAM address width; IMG_W*IMG_H <= 2**ADDR_W.
REQ-005 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-006 SHALL have port rst  input  1  synchronous reset, active-low.
REQ-007 SHALL have port start  input  1  one-cycle pulse that begins one frame pass.
REQ-008 SHALL have port busy  output  1  high from accepted start until done.
REQ-009 SHALL have port done  output  1  one-cycle pulse after the last pixel transfer.
REQ-010 SHALL have port mem_rd  output  1  pixel RAM read strobe.
REQ-011 SHALL have port mem_addr  output  ADDR_W  pixel RAM read address, row-major: y*IMG_W+x.
REQ-012 SHALL have port mem_rdata  input  PIX_W  RAM data, valid exactly 1 cycle after the mem_rd cycle.
REQ-013 SHALL have port request  input  1  hog core can accept a neighbour word.
REQ-014 SHALL have port ready  output  1  o_data holds a valid neighbour word.
REQ-015 SHALL have port o_data  output  4*PIX_W  {top, bot, left, right}, top in MSBs; drives hog i_data.

Function
REQ-016 SHALL implement FSM states IDLE, FETCH, PRESENT, DONE.
REQ-017 IDLE: on start=1, SHALL clear x,y to 0, set busy, and go to FETCH; start in any other state SHALL be ignored.
REQ-018 FETCH: SHALL issue 4 reads on 4 consecutive cycles in order top, bot, left, right, with mem_rd=1 only in those cycles.
REQ-019 FETCH: SHALL capture mem_rdata into the matching o_data field 1 cycle after each read, then enter PRESENT on the cycle after the 4th capture (FETCH = 5 cycles).
REQ-020 Neighbour addresses SHALL clamp at edges (replicate border): top row uses y for top, bottom row uses y for bot, column 0 uses x for left, column IMG_W-1 uses x for right.
REQ-021 PRESENT: ready SHALL be 1 and o_data stable until the transfer cycle (ready=1 and request=1).
REQ-022 A transfer SHALL advance x (raster order, x fastest); at x=IMG_W-1, x wraps to 0 and y increments; next state is FETCH.
REQ-023 A transfer of pixel (IMG_W-1, IMG_H-1) SHALL go to DONE instead of FETCH.
REQ-024 DONE: done=1 for exactly one cycle, busy drops in the same cycle, ready=0, then IDLE.
REQ-025 ready SHALL be 0 in all states other than PRESENT; request in other states SHALL be ignored.
REQ-026 request=0 in PRESENT SHALL hold state, x, y and o_data indefinitely (no timeout).
REQ-027 Exactly IMG_W*IMG_H transfers SHALL occur per frame, with no skipped or duplicated pixels.
REQ-028 mem_addr SHALL be don't-care when mem_rd=0; address arithmetic SHALL be ADDR_W-bit unsigned with no overflow for legal parameters.

Reset
REQ-029 With rst=0 at a clock edge, state SHALL become IDLE, x=y=0, and busy=done=ready=mem_rd=0, o_data=0.
REQ-030 Reset asserted mid-frame (any state) SHALL abort the pass with no done pulse; a later start SHALL restart at pixel (0,0).
REQ-031 start coincident with rst=0 SHALL be ignored.

Verification
Parameters IMG_W=4, IMG_H=3, PIX_W=8; the RAM model returns data = address.
REQ-032 Start with request held at 1 -> first word 0x00040001 for pixel (0,0); 12 transfers; done pulses once after the 12th transfer; busy is high throughout.
REQ-033 Check pixel (1,1) -> o_data=0x01090406; check pixel (3,2) -> o_data=0x070B0A0B (clamped bot and right).
REQ-034 Backpressure: request=0 for 10 cycles in PRESENT -> ready stays 1, o_data unchanged, mem_rd stays 0; release -> exactly one transfer.
REQ-035 start pulsed while busy -> ignored; still exactly 12 transfers and 1 done pulse.
REQ-036 rst=0 during the 5th pixel's FETCH -> next cycle all outputs 0 and IDLE; a new start -> first word 0x00040001.
REQ-037 Timing: mem_rdata is delivered 1 cycle after mem_rd, and ready rises exactly 5 cycles after entering FETCH.
